// File: rtl/mux_4x1_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// mux_4x1_scan_ctrl_if
//   Bundles the scan request, the mux select/output pair and the result
//   handshake of the 4:1 mux scan sequencer.
//
//   Signals
//     start  request a scan (single-cycle pulse, honoured only when idle)
//     mask   channel enable, bit i = scan channel i
//     f      mux output, combinational from s
//     s      mux select driven by the sequencer
//     busy   sequencer is not idle
//     data   assembled word, data[i] = X[i] seen through the mux
//     valid  result available
//     ready  consumer accepts data when valid & ready at a rising edge
//     par    even parity of data (only with MUX_SCAN_PARITY_EN)
//
//   Modports
//     slave  : the scan sequencer
//     master : the requester / mux / consumer side
//
//   Optional feature macro: MUX_SCAN_PARITY_EN
// ----------------------------------------------------------------------------
interface mux_4x1_scan_ctrl_if;
    logic       start;
    logic [3:0] mask;
    logic       f;
    logic [1:0] s;
    logic       busy;
    logic [3:0] data;
    logic       valid;
    logic       ready;
`ifdef MUX_SCAN_PARITY_EN
    logic       par;
`endif

    modport slave (
        input  start,
        input  mask,
        input  f,
        input  ready,
        output s,
        output busy,
        output data,
`ifdef MUX_SCAN_PARITY_EN
        output par,
`endif
        output valid
    );

    modport master (
        output start,
        output mask,
        output f,
        output ready,
        input  s,
        input  busy,
        input  data,
`ifdef MUX_SCAN_PARITY_EN
        input  par,
`endif
        input  valid
    );
endinterface

// File: rtl/mux_4x1_scan_ctrl.sv
// ----------------------------------------------------------------------------
// mux_4x1_scan_ctrl
//   Sequencer for a 4:1 mux. On an accepted start it walks the select through
//   every enabled channel in ascending order, holding each one for
//   SETTLE_CYC+1 cycles and sampling the mux output on the last of them.
//   The samples form a 4-bit word that is offered on a valid/ready handshake.
//
//   Parameters
//     SETTLE_CYC  extra cycles the select is held before sampling (0..15)
//     IDLE_SEL    select value driven while idle or holding a result
//
//   Ports
//     clk_i    clock, rising edge
//     rst_i    asynchronous active-high reset
//     scan_if  slave side of mux_4x1_scan_ctrl_if (start/mask/f/s/busy/
//              data/valid/ready, plus par when the parity option is built)
//
//   Optional feature macro: MUX_SCAN_PARITY_EN
//     When defined, scan_if.par carries the even parity of data, registered
//     together with data when the result is presented.
// ----------------------------------------------------------------------------
module mux_4x1_scan_ctrl #(
    parameter int unsigned SETTLE_CYC = 1,
    parameter logic [1:0]  IDLE_SEL   = 2'b00
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mux_4x1_scan_ctrl_if.slave scan_if
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t     state_q;
    logic [1:0] s_q;
    logic [3:0] cnt_q;
    logic [3:0] mask_q;
    logic [3:0] data_q;
    logic       valid_q;
    logic       busy_q;
`ifdef MUX_SCAN_PARITY_EN
    logic       par_q;
`endif

    // Lowest set bit of a channel vector; callers only use it on non-zero
    // vectors, so the fall-through value is never relied upon.
    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // higher_mask[gi] = enabled channels strictly above channel gi. Indexing
    // it with the current select gives the channels still to be scanned.
    logic [3:0] higher_mask [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_higher
        for (genvar gj = 0; gj < 4; gj++) begin : g_bit
            if (gj > gi) begin : g_above
                assign higher_mask[gi][gj] = mask_q[gj];
            end else begin : g_not_above
                assign higher_mask[gi][gj] = 1'b0;
            end
        end
    end

    logic [3:0] remain_mask;
    logic [3:0] data_smp;

    assign remain_mask = higher_mask[s_q];

    // Current word with the channel under the select replaced by the mux output.
    always_comb begin
        data_smp       = data_q;
        data_smp[s_q]  = scan_if.f;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            s_q     <= IDLE_SEL;
            cnt_q   <= 4'd0;
            mask_q  <= 4'd0;
            data_q  <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_if.start) begin
                        mask_q <= scan_if.mask;
                        data_q <= 4'd0;
                        busy_q <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                        par_q  <= 1'b0;
`endif
                        if (scan_if.mask != 4'd0) begin
                            state_q <= ST_SETTLE;
                            s_q     <= lowest_idx(scan_if.mask);
                            cnt_q   <= CNT_LOAD;
                        end else begin
                            // Nothing to scan: present an all-zero result at once.
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        data_q <= data_smp;
                        if (remain_mask != 4'd0) begin
                            s_q   <= lowest_idx(remain_mask);
                            cnt_q <= CNT_LOAD;
                        end else begin
                            state_q <= ST_HOLD;
                            s_q     <= IDLE_SEL;
                            valid_q <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
                            par_q   <= ^data_smp;
`endif
                        end
                    end
                end

                ST_HOLD: begin
                    // valid_q is always set in this state, so ready alone
                    // completes the handshake. Data is left untouched.
                    if (scan_if.ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    s_q     <= IDLE_SEL;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign scan_if.s     = s_q;
    assign scan_if.busy  = busy_q;
    assign scan_if.data  = data_q;
    assign scan_if.valid = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    assign scan_if.par   = par_q;
`endif

endmodule

// File: tb/tb_mux_4x1_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mux_4x1_scan_ctrl
//   Drives directed and random scans into mux_4x1_scan_ctrl with a 4:1 mux
//   modelled as f = x[s]. Expected select sequences, latencies and result
//   words come from a channel-list model built from the mask.
//   Optional feature macro: MUX_SCAN_PARITY_EN
// ----------------------------------------------------------------------------
module tb_mux_4x1_scan_ctrl;

    localparam int unsigned SETTLE   = 1;
    localparam logic [1:0]  IDLE_SEL = 2'b00;

    logic       clk;
    logic       rst;
    logic [3:0] x;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    mux_4x1_scan_ctrl_if bus ();

    assign bus.f = x[bus.s];

    mux_4x1_scan_ctrl #(
        .SETTLE_CYC (SETTLE),
        .IDLE_SEL   (IDLE_SEL)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .scan_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] exp_data);
        chk({tag, "_busy"},  32'(bus.busy),  32'd0);
        chk({tag, "_valid"}, 32'(bus.valid), 32'd0);
        chk({tag, "_s"},     32'(bus.s),     32'(IDLE_SEL));
        chk({tag, "_data"},  32'(bus.data),  32'(exp_data));
    endtask

    // One full transaction: start, walk, hold for hold_cyc cycles, handshake.
    // start_in_hold additionally pulses START during the hold and together
    // with the completing handshake; both must be ignored.
    task automatic do_scan(input logic [3:0] m, input logic [3:0] xv,
                           input int hold_cyc, input bit start_in_hold);
        int         exp_s[$];
        int         lat;
        logic [3:0] exp_data;
        exp_s = {};
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                for (int r = 0; r <= int'(SETTLE); r++) exp_s.push_back(i);
            end
        end
        lat      = 1 + exp_s.size();
        exp_data = xv & m;

        @(negedge clk);
        chk("pre_busy", 32'(bus.busy), 32'd0);
        chk("pre_s",    32'(bus.s),    32'(IDLE_SEL));
        bus.start = 1'b1;
        bus.mask  = m;
        bus.ready = 1'b0;
        x         = xv;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mask  = 4'($urandom);   // must not disturb the latched mask

        for (int k = 1; k < lat; k++) begin
            chk("scan_s",     32'(bus.s),     32'(exp_s[k-1]));
            chk("scan_valid", 32'(bus.valid), 32'd0);
            chk("scan_busy",  32'(bus.busy),  32'd1);
            bus.ready = 1'($urandom);   // ignored while valid is low
            @(negedge clk);
        end

        chk("res_valid", 32'(bus.valid), 32'd1);
        chk("res_data",  32'(bus.data),  32'(exp_data));
        chk("res_s",     32'(bus.s),     32'(IDLE_SEL));
        chk("res_busy",  32'(bus.busy),  32'd1);
`ifdef MUX_SCAN_PARITY_EN
        chk("res_par",   32'(bus.par),   32'(^exp_data));
`endif
        bus.ready = 1'b0;

        for (int h = 0; h < hold_cyc; h++) begin
            bus.start = start_in_hold && (h == 0);
            bus.mask  = 4'($urandom);
            @(negedge clk);
            bus.start = 1'b0;
            chk("hold_valid", 32'(bus.valid), 32'd1);
            chk("hold_data",  32'(bus.data),  32'(exp_data));
            chk("hold_busy",  32'(bus.busy),  32'd1);
            chk("hold_s",     32'(bus.s),     32'(IDLE_SEL));
        end

        bus.ready = 1'b1;
        bus.start = start_in_hold;
        bus.mask  = 4'b1111;
        @(negedge clk);
        bus.ready = 1'b0;
        bus.start = 1'b0;
        chk_idle("done", exp_data);
        @(negedge clk);
        chk_idle("after", exp_data);

        $display("scan mask=%b x=%b data=%b exp=%b lat=%0d hold=%0d start_in_hold=%0b",
                 m, xv, bus.data, exp_data, lat, hold_cyc, start_in_hold);
    endtask

    initial begin
        rst       = 1'b1;
        x         = 4'd0;
        bus.start = 1'b0;
        bus.mask  = 4'd0;
        bus.ready = 1'b0;

        #1;
        chk_idle("reset", 4'd0);
`ifdef MUX_SCAN_PARITY_EN
        chk("reset_par", 32'(bus.par), 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases.
        do_scan(4'b1111, 4'b1010, 0, 1'b0);
        do_scan(4'b0101, 4'b1111, 1, 1'b0);
        do_scan(4'b0000, 4'b1111, 2, 1'b0);
        do_scan(4'b1001, 4'b0111, 5, 1'b1);
        do_scan(4'b1111, 4'b1011, 0, 1'b0);
        do_scan(4'b1111, 4'b1001, 0, 1'b0);

        // Reset while channel 2 is selected mid-scan.
        begin
            bit found;
            found = 1'b0;
            @(negedge clk);
            bus.start = 1'b1;
            bus.mask  = 4'b1111;
            x         = 4'b1111;
            @(negedge clk);
            bus.start = 1'b0;
            for (int k = 0; k < 20 && !found; k++) begin
                if (bus.s == 2'd2) found = 1'b1;
                else @(negedge clk);
            end
            chk("rst_reach_s2", 32'(found), 32'd1);
            #2 rst = 1'b1;
            #1;
            chk_idle("async_rst", 4'd0);
`ifdef MUX_SCAN_PARITY_EN
            chk("async_rst_par", 32'(bus.par), 32'd0);
`endif
            @(negedge clk);
            chk_idle("rst_held", 4'd0);
            rst = 1'b0;
            $display("reset mid-scan at s=2 busy=%0b data=%b", bus.busy, bus.data);
        end
        do_scan(4'b1111, 4'b0110, 0, 1'b0);

        // Random cases.
        for (int t = 0; t < 24; t++) begin
            do_scan(4'($urandom), 4'($urandom), int'($urandom_range(0, 5)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
